// File: rtl/dump_pkg.sv
// Shared types for the end-of-run dump sequencer: record tags, FSM states and the record payload.
package dump_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KIND_W = 2;

  typedef logic [KIND_W-1:0] kind_t;

  localparam kind_t KIND_PC  = 2'd0;
  localparam kind_t KIND_REG = 2'd1;
  localparam kind_t KIND_MEM = 2'd2;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DREG = 2'd1,
    DMEM = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    kind_t             kind;
    logic [DATA_W-1:0] data;
  } rec_t;

endpackage

// File: rtl/dump_out_slot.sv
// Single-entry output register: accepts a record when empty or draining, holds it under back-pressure.
module dump_out_slot
  import dump_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  rec_t rec_i,
  input  logic ready_i,
  output logic valid_o,
  output rec_t rec_o,
  output logic free_c_o
);

  logic valid_q, valid_d;
  rec_t rec_q, rec_d;

  assign free_c_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i && free_c_o) begin
      valid_d = 1'b1;
      rec_d   = rec_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;

endmodule

// File: rtl/dump_sequencer.sv
// End-of-run observer: streams fetch PCs while the program runs, then dumps the register file
// and a data-memory window as tagged, back-pressured records.
module dump_sequencer
  import dump_pkg::*;
#(
  parameter int unsigned NREGS     = 32,
  parameter logic [31:0] MEM_BASE  = 32'h4000,
  parameter int unsigned MEM_WORDS = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [31:0] out_data,
  output logic [15:0] drop_cnt,
  output logic        done
);

  localparam int unsigned IDX_W  = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DROP_W = 16;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                done_q, done_d;
  logic                load_c;
  rec_t                rec_c;
  rec_t                slot_rec;
  logic                slot_free_c;

  dump_out_slot u_slot (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_c),
    .rec_i    (rec_c),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .rec_o    (slot_rec),
    .free_c_o (slot_free_c)
  );

  // Read ports only sweep while their dump phase is active.
  assign rf_raddr  = (state_q == DREG) ? idx_q[4:0] : 5'd0;
  assign mem_raddr = (state_q == DMEM) ? (MEM_BASE + idx_q) : MEM_BASE;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    done_d  = done_q;
    load_c  = 1'b0;
    rec_c   = '0;
    case (state_q)
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (slot_free_c) begin
          load_c = 1'b1;
          rec_c  = '{kind: KIND_PC, data: pc};
        end else if (drop_q != {DROP_W{1'b1}}) begin
          drop_d = drop_q + DROP_W'(1);
        end
        // Exact compare: an unknown instruction must not end the run.
        if ((inst === 32'h0) || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d = DREG;
          idx_d   = '0;
        end
      end
      DREG: begin
        if (slot_free_c) begin
          load_c = 1'b1;
          rec_c  = '{kind: KIND_REG, data: rf_rdata};
          if (idx_q == IDX_W'(NREGS - 1)) begin
            idx_d   = '0;
            state_d = DMEM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DMEM: begin
        if (slot_free_c) begin
          load_c = 1'b1;
          rec_c  = '{kind: KIND_MEM, data: mem_rdata};
          if (idx_q == IDX_W'(MEM_WORDS - 1)) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        // Nothing loads here, so a free slot means it is empty after this edge.
        if (slot_free_c) begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      idx_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
    end
  end

  assign out_kind = slot_rec.kind;
  assign out_data = slot_rec.data;
  assign drop_cnt = drop_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Scoreboard bench for dump_sequencer: directed runs push expected records, a negedge monitor checks them.
module tb_dump_sequencer;
  import dump_pkg::*;

  localparam int unsigned NREGS     = 32;
  localparam int unsigned MEM_WORDS = 4;
  localparam logic [31:0] MEM_BASE  = 32'h4000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = NOP;
  logic        out_ready = 1'b1;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [1:0]  out_kind;
  logic [31:0] out_data;
  logic [15:0] drop_cnt;
  logic        done;

  logic        s_reset = 1'b0;
  logic [31:0] s_pc = '0;
  logic [31:0] s_inst = NOP;
  logic        s_ready = 1'b0;
  logic [4:0]  s_rf_raddr;
  logic [31:0] s_rf_rdata;
  logic [31:0] s_mem_raddr;
  logic [31:0] s_mem_rdata;
  logic        s_out_valid;
  logic [1:0]  s_out_kind;
  logic [31:0] s_out_data;
  logic [15:0] s_drop_cnt;
  logic        s_done;

  logic [31:0] rf [NREGS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hD00D, a[15:0]};
  endfunction

  assign rf_rdata    = rf[rf_raddr];
  assign mem_rdata   = mem_word(mem_raddr);
  assign s_rf_rdata  = rf[s_rf_raddr];
  assign s_mem_rdata = mem_word(s_mem_raddr);

  dump_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .inst      (inst),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt),
    .done      (done)
  );

  dump_sequencer #(.TIMEOUT(70000)) dut_sat (
    .clk       (clk),
    .reset     (s_reset),
    .pc        (s_pc),
    .inst      (s_inst),
    .rf_raddr  (s_rf_raddr),
    .rf_rdata  (s_rf_rdata),
    .mem_raddr (s_mem_raddr),
    .mem_rdata (s_mem_rdata),
    .out_valid (s_out_valid),
    .out_ready (s_ready),
    .out_kind  (s_out_kind),
    .out_data  (s_out_data),
    .drop_cnt  (s_drop_cnt),
    .done      (s_done)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q[$];
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;
  rec_t prev_rec = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every transfer pops one expected record; a stalled record must not change.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_rec", {30'd0, out_kind} ^ out_data, {30'd0, prev_rec.kind} ^ prev_rec.data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_record: got kind %0d data %h, required none", out_kind, out_data);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          chk("rec_kind", 32'(out_kind), 32'(e.kind));
          chk("rec_data", out_data, e.data);
        end
      end
      prev_stall = reset && out_valid && !out_ready;
      prev_rec   = '{kind: out_kind, data: out_data};
    end
  end

  task automatic cyc(input logic [31:0] p, input logic [31:0] i, input logic r);
    pc        = p;
    inst      = i;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input kind_t k, input logic [31:0] d);
    exp_q.push_back('{kind: k, data: d});
  endtask

  task automatic push_dump();
    for (int i = 0; i < NREGS; i++) push(KIND_REG, rf[i]);
    for (int j = 0; j < MEM_WORDS; j++) push(KIND_MEM, 32'hD00D_4000 + 32'(j));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(32'h0, NOP, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_kind", 32'(out_kind), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_mem_raddr", mem_raddr, MEM_BASE);
    cyc(32'h0, NOP, 1'b1);
    exp_q.delete();
    mon_en = 1'b1;
    reset  = 1'b1;
  endtask

  task automatic wait_empty(input string nm);
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) cyc(32'hDEAD_0000, NOP, 1'b1);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0111;
    rf[7] = 32'hFACE_0001;
    rf[8] = 32'hA0B0_C0D0;
    rf[9] = 32'h0096_311C;
    @(posedge clk);
    #1;

    // Halt on zero instruction with exact dump timing.
    do_reset();
    for (int k = 0; k < 6; k++) push(KIND_PC, 32'(4 * k));
    push_dump();
    for (int k = 0; k < 6; k++) cyc(32'(4 * k), (k < 5) ? NOP : 32'h0, 1'b1);
    chk("dreg_rf_raddr0", 32'(rf_raddr), 32'd0);
    repeat (32) cyc(32'hDEAD_0000, NOP, 1'b1);
    chk("dmem_raddr0", mem_raddr, 32'h0000_4000);
    repeat (4) cyc(32'hDEAD_0000, NOP, 1'b1);
    chk("last_mem_done_low", 32'(done), 32'd0);
    chk("last_mem_valid", 32'(out_valid), 32'd1);
    chk("last_mem_kind", 32'(out_kind), 32'(KIND_MEM));
    chk("last_mem_data", out_data, 32'hD00D_4003);
    cyc(32'hDEAD_0000, NOP, 1'b1);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_valid_idle", 32'(out_valid), 32'd0);
    chk("halt_drop", 32'(drop_cnt), 32'd0);
    chk("halt_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 10; k++) cyc(32'(k * 8), (k % 2 == 0) ? 32'h0 : NOP, k[0]);
    chk("sticky_done", 32'(done), 32'd1);
    chk("sticky_valid", 32'(out_valid), 32'd0);

    // Timeout after 64 run cycles.
    do_reset();
    for (int k = 0; k < 64; k++) push(KIND_PC, 32'(4 * k));
    push_dump();
    for (int k = 0; k < 64; k++) cyc(32'(4 * k), NOP, 1'b1);
    chk("to_last_pc", out_data, 32'd252);
    wait_empty("to_sb_drain");
    chk("to_done", 32'(done), 32'd1);
    chk("to_drop", 32'(drop_cnt), 32'd0);

    // Back-pressure during RUN and during DREG.
    do_reset();
    push(KIND_PC, 32'd0);
    for (int k = 4; k < 10; k++) push(KIND_PC, 32'(4 * k));
    push_dump();
    for (int k = 0; k < 10; k++) begin
      if (k == 4) chk("bp_drop_run", 32'(drop_cnt), 32'd3);
      cyc(32'(4 * k), (k == 9) ? 32'h0 : NOP, !(k >= 1 && k <= 3));
    end
    repeat (5) cyc(32'hDEAD_0000, NOP, 1'b1);
    repeat (4) cyc(32'hDEAD_0000, NOP, 1'b0);
    wait_empty("bp_sb_drain");
    chk("bp_drop_final", 32'(drop_cnt), 32'd3);
    chk("bp_done", 32'(done), 32'd1);

    // Reset in the middle of the register dump, then a clean rerun.
    do_reset();
    for (int k = 0; k < 3; k++) push(KIND_PC, 32'(4 * k));
    for (int i = 0; i < 10; i++) push(KIND_REG, rf[i]);
    for (int k = 0; k < 3; k++) cyc(32'(4 * k), (k == 2) ? 32'h0 : NOP, 1'b1);
    repeat (10) cyc(32'hDEAD_0000, NOP, 1'b1);
    chk("mid_rf_raddr", 32'(rf_raddr), 32'd10);
    reset = 1'b0;
    cyc(32'h0, NOP, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sb", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) push(KIND_PC, 32'(4 * k));
    push_dump();
    for (int k = 0; k < 3; k++) cyc(32'(4 * k), (k == 2) ? 32'h0 : NOP, 1'b1);
    wait_empty("rerun_sb_drain");
    chk("rerun_done", 32'(done), 32'd1);

    // Drop-counter saturation on the long-timeout instance.
    s_reset = 1'b0;
    s_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_reset = 1'b1;
    for (int k = 0; k < 66000; k++) begin
      s_pc = 32'(4 * k);
      @(posedge clk);
      #1;
    end
    chk("sat_drop", 32'(s_drop_cnt), 32'h0000_FFFF);
    chk("sat_hold_valid", 32'(s_out_valid), 32'd1);
    chk("sat_hold_data", s_out_data, 32'd0);
    s_inst  = 32'h0;
    s_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("sat_done", 32'(s_done), 32'd1);
    chk("sat_drop_kept", 32'(s_drop_cnt), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
